// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for RV32M/RV64M DIV/REM and W variants.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and zero dividend finish in one cycle.
module div_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_signed,
    input  logic            is_rem,
    input  logic            is_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);
    localparam int SH = XLEN - 32;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg;
    logic [XLEN-1:0] rem_reg, quo_reg, dvs_reg, dvd_reg, result_reg;
    logic            rem_sel_reg, word_reg, neg_q_reg, neg_r_reg, dz_reg, ovf_reg;

    // Sign-extend the low 32 bits when w is set; identity otherwise.
    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] v, input logic w);
        logic signed [XLEN-1:0] t;
        t = $signed(v << SH);
        t = t >>> SH;
        return w ? t : v;
    endfunction

    function automatic logic [XLEN-1:0] finish_val(
        input logic            rsel,
        input logic            w,
        input logic            dz,
        input logic            ovf,
        input logic            neg,
        input logic [XLEN-1:0] quo,
        input logic [XLEN-1:0] rem,
        input logic [XLEN-1:0] dvd
    );
        logic [XLEN-1:0] v;
        v = rsel ? rem : quo;
        if (neg) v = -v;
        if (dz)       v = rsel ? dvd : '1;
        else if (ovf) v = rsel ? '0 : dvd;
        return sext_w(v, w);
    endfunction

    logic            word_in, sign_a, sign_b, dz_in, ovf_in, accept;
    logic [31:0]     a32_neg, b32_neg;
    logic [XLEN-1:0] a_trunc, mag_a, mag_b, q_init;
    logic [XLEN:0]   rem_sh, diff;
    logic            q_bit;
    logic [XLEN-1:0] rem_step;

    always_comb begin
        word_in = (XLEN == 64) && is_word;
        a32_neg = -src1[31:0];
        b32_neg = -src2[31:0];
        a_trunc = word_in ? XLEN'(src1[31:0]) : src1;
        sign_a  = word_in ? src1[31] : src1[XLEN-1];
        sign_b  = word_in ? src2[31] : src2[XLEN-1];
        if (is_signed && sign_a) mag_a = word_in ? XLEN'(a32_neg) : -src1;
        else                     mag_a = a_trunc;
        if (is_signed && sign_b) mag_b = word_in ? XLEN'(b32_neg) : -src2;
        else                     mag_b = word_in ? XLEN'(src2[31:0]) : src2;
        dz_in   = word_in ? (src2[31:0] == 32'd0) : (src2 == '0);
        if (word_in)
            ovf_in = is_signed && (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF);
        else
            ovf_in = is_signed && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
        // Left-align the dividend so the quotient always shifts out of the MSB.
        q_init  = word_in ? (mag_a << SH) : mag_a;
        accept  = in_valid && (state_reg == IDLE) && !flush;
    end

    always_comb begin
        rem_sh   = {rem_reg, quo_reg[XLEN-1]};
        diff     = rem_sh - {1'b0, dvs_reg};
        q_bit    = ~diff[XLEN];
        rem_step = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    end

`ifdef DIV_FAST_SPECIAL_EN
    logic            fast_hit;
    logic [XLEN-1:0] fast_val;
    always_comb begin
        fast_hit = dz_in || ovf_in || (a_trunc == '0);
        fast_val = finish_val(is_rem, word_in, dz_in, ovf_in, 1'b0, '0, '0, a_trunc);
    end
`endif

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (in_valid) begin
`ifdef DIV_FAST_SPECIAL_EN
                    state_next = fast_hit ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
                CALC: if (cnt_reg == '0) state_next = FIX;
                FIX:  state_next = DONE;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg     <= '0;
            rem_reg     <= '0;
            quo_reg     <= '0;
            dvs_reg     <= '0;
            dvd_reg     <= '0;
            result_reg  <= '0;
            rem_sel_reg <= 1'b0;
            word_reg    <= 1'b0;
            neg_q_reg   <= 1'b0;
            neg_r_reg   <= 1'b0;
            dz_reg      <= 1'b0;
            ovf_reg     <= 1'b0;
        end else if (accept) begin
            cnt_reg     <= word_in ? CW'(31) : CW'(XLEN-1);
            rem_reg     <= '0;
            quo_reg     <= q_init;
            dvs_reg     <= mag_b;
            dvd_reg     <= a_trunc;
            rem_sel_reg <= is_rem;
            word_reg    <= word_in;
            neg_q_reg   <= is_signed && (sign_a ^ sign_b);
            neg_r_reg   <= is_signed && sign_a;
            dz_reg      <= dz_in;
            ovf_reg     <= ovf_in;
`ifdef DIV_FAST_SPECIAL_EN
            if (fast_hit) result_reg <= fast_val;
`endif
        end else if (!flush && state_reg == CALC) begin
            rem_reg <= rem_step;
            quo_reg <= {quo_reg[XLEN-2:0], q_bit};
            if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
        end else if (!flush && state_reg == FIX) begin
            result_reg <= finish_val(rem_sel_reg, word_reg, dz_reg, ovf_reg,
                                     rem_sel_reg ? neg_r_reg : neg_q_reg,
                                     quo_reg, rem_reg, dvd_reg);
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: a driver queues expected results, a monitor checks value and latency.
module tb_div_iter;
    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0, is_signed = 1'b0, is_rem = 1'b0, is_word = 1'b0;
    logic [XLEN-1:0] src1 = '0, src2 = '0;
    logic            flush = 1'b0, out_ready = 1'b1;
    logic            in_ready, out_valid, busy;
    logic [XLEN-1:0] result;

    div_iter #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .is_signed(is_signed), .is_rem(is_rem), .is_word(is_word),
        .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [63:0] ref_model(input bit s, input bit r, input bit w,
                                              input logic [63:0] a, input logic [63:0] b);
        logic [31:0] a32, b32, q32, r32, v32;
        logic [63:0] q64, r64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 0) begin q32 = '1; r32 = a32; end
            else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = 0; end
            else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
            else begin q32 = a32 / b32; r32 = a32 % b32; end
            v32 = r ? r32 : q32;
            return {{32{v32[31]}}, v32};
        end
        if (b == 0) begin q64 = '1; r64 = a; end
        else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q64 = a; r64 = 0; end
        else if (s) begin q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b); end
        else begin q64 = a / b; r64 = a % b; end
        return r ? r64 : q64;
    endfunction

    function automatic int exp_lat(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
        bit dz, ov, az;
        dz = w ? (b[31:0] == 0) : (b == 0);
        az = w ? (a[31:0] == 0) : (a == 0);
        ov = s && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                     : (a == 64'h8000_0000_0000_0000 && b == '1));
`ifdef DIV_FAST_SPECIAL_EN
        if (dz || ov || az) return 1;
`else
        if (dz && ov && az) return 0;
`endif
        return (w ? 32 : 64) + 2;
    endfunction

    task automatic issue(input bit s, input bit r, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] expv, input bit push);
        int n;
        @(negedge clk);
        is_signed = s; is_rem = r; is_word = w; src1 = a; src2 = b; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            in_valid = 1'b0;
            return;
        end
        if (push) sb.push_back('{expv, exp_lat(s, w, a, b), cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    task automatic run(input bit s, input bit r, input bit w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] expv);
        issue(s, r, w, a, b, expv, 1'b1);
        wait_idle();
    endtask

    // Monitor: pops on each rising out_valid, checks value/latency, then stability while held.
    initial begin
        bit          prev;
        logic [63:0] held;
        exp_t        e;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_out_valid actual=%h required=none", result);
                    end else begin
                        e = sb.pop_front();
                        check("result", result, e.res);
                        check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
                        $display("txn result=%h latency=%0d", result, cyc - e.acc + 1);
                    end
                    held = result;
                end else if (out_valid && prev) begin
                    check("result_stable", result, held);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          s, r, w;
        int          sel;
        int          n;
        logic [63:0] a, b;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);

        run(0, 0, 0, 64'd100, 64'd7, 64'd14);
        run(0, 1, 0, 64'd100, 64'd7, 64'd2);
        run(1, 0, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run(1, 1, 0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        run(1, 1, 0, 64'd7, -64'sd2, 64'd1);
        run(0, 0, 0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run(1, 1, 0, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB);
        run(1, 0, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
        run(1, 1, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'd0);
        run(1, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        run(0, 0, 1, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        run(1, 0, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run(0, 0, 0, 64'd0, 64'd5, 64'd0);

        // Consumer stalls for 10 cycles in DONE.
        out_ready = 1'b0;
        issue(0, 0, 0, 64'd100, 64'd7, 64'd14, 1'b1);
        n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        repeat (10) begin
            @(negedge clk);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        wait_idle();

        // Flush mid-CALC, then a clean request.
        issue(0, 0, 0, 64'd100, 64'd7, 64'd0, 1'b0);
        repeat (19) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        repeat (80) begin
            @(negedge clk);
            check("flush_no_valid", 64'(out_valid), 64'd0);
        end
        run(0, 0, 0, 64'd100, 64'd7, 64'd14);

        // flush with in_valid in IDLE must not accept.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; src1 = 64'd100; src2 = 64'd7;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // Asynchronous reset mid-CALC.
        issue(1, 0, 0, 64'd12345, 64'd17, 64'd0, 1'b0);
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_result", result, 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            case (sel)
                0: b = 64'd0;
                1: begin
                    b = 64'($urandom_range(1, 20));
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
                2: begin
                    s = 1'b1;
                    a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = '1;
                end
                3: a = 64'd0;
                4: b = {32'd0, 16'd0, 16'($urandom)};
                default: ;
            endcase
            run(s, r, w, a, b, ref_model(s, r, w, a, b));
        end

        repeat (5) @(negedge clk);
        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL pending_results actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
